// File: rtl/srio_ireq_pkg.sv
// Shared definitions for the SRIO initiator-request path: packet types,
// packet size limit and the arbiter state encoding.
package srio_ireq_pkg;

   // FTYPE codes carried by the local requesters
   localparam logic [3:0] FTYPE_DOORB = 4'hA;
   localparam logic [3:0] FTYPE_NWR   = 4'h5;
   localparam logic [3:0] FTYPE_TNWR  = 4'h4;

   // 1 header beat + 32 x 8-byte data beats = 256-byte payload ceiling
   localparam int MAX_BEATS_DEF = 33;

   // Beat counter width; must be able to represent MAX_BEATS
   localparam int BEAT_CNT_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: the first asserted valid bit found when
// searching upward from last_i+1 (mod NUM_REQ). Shared by the ireq arbiter
// and any later iresp/tresp arbiters.
module rr_arb_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] pick_oh_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               any_o
);

   logic found_s;
   logic hit_s;

   // Walk the candidates in priority order; the first valid one wins
   always_comb begin
      pick_oh_o  = '0;
      pick_idx_o = '0;
      found_s    = 1'b0;
      hit_s      = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            hit_s        = !found_s && valid_i[j] &&
                           (j == ((int'(last_i) + k) % NUM_REQ));
            pick_oh_o[j] = pick_oh_o[j] | hit_s;
            pick_idx_o   = hit_s ? IDX_W'(j) : pick_idx_o;
            found_s      = found_s | hit_s;
         end
      end
   end

   assign any_o = |valid_i;

endmodule

// File: rtl/ireq_arbiter.sv
// Packet-granular round-robin arbiter for the SRIO ireq AXI-Stream channel.
// One requester owns the channel from its first beat to its tlast; packets
// longer than MAX_BEATS are cut with a forced tlast and the remainder of the
// source packet is drained and discarded.
module ireq_arbiter
   import srio_ireq_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BEATS = MAX_BEATS_DEF,
   parameter int CNT_W     = 16
) (
   input  logic                     log_clk,
   input  logic                     log_rst_n,
   input  logic                     link_initialized,
   input  logic [NUM_REQ-1:0]       req_tvalid_in,
   output logic [NUM_REQ-1:0]       req_tready_o,
   input  logic [NUM_REQ-1:0]       req_tlast_in,
   input  logic [64*NUM_REQ-1:0]    req_tdata_in,
   input  logic [8*NUM_REQ-1:0]     req_tkeep_in,
   input  logic [32*NUM_REQ-1:0]    req_tuser_in,
   output logic                     ireq_tvalid_o,
   input  logic                     ireq_tready_in,
   output logic                     ireq_tlast_o,
   output logic [63:0]              ireq_tdata_o,
   output logic [7:0]               ireq_tkeep_o,
   output logic [31:0]              ireq_tuser_o,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic                     busy_o,
   output logic                     overrun_o,
   output logic [CNT_W*NUM_REQ-1:0] pkt_cnt_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BEATS - 1);

   arb_state_e                      state_q, state_d;
   logic [NUM_REQ-1:0]              grant_q, grant_d;
   logic [IDX_W-1:0]                grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]                last_grant_q, last_grant_d;
   logic [BEAT_CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
   logic                            overrun_q, overrun_d;
   logic [NUM_REQ-1:0][CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

   logic [NUM_REQ-1:0] pick_oh_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic               pick_any_s;

   logic [NUM_REQ-1:0] xfer_mask_s;
   logic               sel_valid_s;
   logic               sel_last_s;
   logic [63:0]        sel_data_s;
   logic [7:0]         sel_keep_s;
   logic [31:0]        sel_user_s;
   logic               own_valid_s;
   logic               own_last_s;
   logic               at_limit_s;
   logic               xfer_hs_s;
   logic               drain_hs_s;

   rr_arb_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .valid_i    (req_tvalid_in),
      .last_i     (last_grant_q),
      .pick_oh_o  (pick_oh_s),
      .pick_idx_o (pick_idx_s),
      .any_o      (pick_any_s)
   );

   // Zero-latency AND-OR mux of the owner's stream; all-zero unless in XFER
   always_comb begin
      xfer_mask_s = (state_q == ST_XFER) ? grant_q : '0;
      sel_data_s  = 64'h0;
      sel_keep_s  = 8'h00;
      sel_user_s  = 32'h0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_data_s = sel_data_s | (req_tdata_in[i*64 +: 64] & {64{xfer_mask_s[i]}});
         sel_keep_s = sel_keep_s | (req_tkeep_in[i*8 +: 8]   & {8{xfer_mask_s[i]}});
         sel_user_s = sel_user_s | (req_tuser_in[i*32 +: 32] & {32{xfer_mask_s[i]}});
      end
      sel_valid_s = |(req_tvalid_in & xfer_mask_s);
      sel_last_s  = |(req_tlast_in & xfer_mask_s);
      own_valid_s = |(req_tvalid_in & grant_q);
      own_last_s  = |(req_tlast_in & grant_q);
      at_limit_s  = (beat_cnt_q == LAST_BEAT);
      xfer_hs_s   = sel_valid_s && ireq_tready_in;
      drain_hs_s  = (state_q == ST_DRAIN) && own_valid_s;
   end

   // Ready steering: owner follows downstream in XFER, swallows beats in DRAIN
   always_comb begin
      case (state_q)
         ST_XFER:  req_tready_o = grant_q & {NUM_REQ{ireq_tready_in}};
         ST_DRAIN: req_tready_o = grant_q;
         default:  req_tready_o = '0;
      endcase
   end

   assign ireq_tvalid_o = sel_valid_s;
   assign ireq_tlast_o  = sel_last_s || ((state_q == ST_XFER) && at_limit_s);
   assign ireq_tdata_o  = sel_data_s;
   assign ireq_tkeep_o  = sel_keep_s;
   assign ireq_tuser_o  = sel_user_s;
   assign grant_o       = grant_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign overrun_o     = overrun_q;
   assign pkt_cnt_o     = pkt_cnt_q;

   // Next-state: grant in IDLE, track beats in XFER, discard tail in DRAIN
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_idx_d  = grant_idx_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      overrun_d    = 1'b0;
      pkt_cnt_d    = pkt_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (link_initialized && pick_any_s) begin
               state_d     = ST_XFER;
               grant_d     = pick_oh_s;
               grant_idx_d = pick_idx_s;
               beat_cnt_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_XFER: begin
            if (xfer_hs_s && sel_last_s) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_W'(grant_q[i]);
               end
               last_grant_d = grant_idx_q;
               grant_d      = '0;
               state_d      = ST_IDLE;
            end else if (xfer_hs_s && at_limit_s) begin
               overrun_d = 1'b1;
               state_d   = ST_DRAIN;
            end else if (xfer_hs_s) begin
               beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end else begin
               state_d = ST_XFER;
            end
         end
         ST_DRAIN: begin
            if (drain_hs_s && own_last_s) begin
               last_grant_d = grant_idx_q;
               grant_d      = '0;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State and bookkeeping registers; requester 0 has priority after reset
   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         grant_idx_q  <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
         overrun_q    <= 1'b0;
         pkt_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_idx_q  <= grant_idx_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         overrun_q    <= overrun_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

endmodule

// File: tb/tb_ireq_arbiter.sv
// Directed bench for ireq_arbiter with two requesters driven from a small
// per-requester packet source model.
module tb_ireq_arbiter;

   logic         clk;
   logic         rst_n;
   logic         link;
   logic [1:0]   req_tvalid;
   logic [1:0]   req_tready_o;
   logic [1:0]   req_tlast;
   logic [127:0] req_tdata;
   logic [15:0]  req_tkeep;
   logic [63:0]  req_tuser;
   logic         ireq_tvalid_o;
   logic         ireq_tready;
   logic         ireq_tlast_o;
   logic [63:0]  ireq_tdata_o;
   logic [7:0]   ireq_tkeep_o;
   logic [31:0]  ireq_tuser_o;
   logic [1:0]   grant_o;
   logic         busy_o;
   logic         overrun_o;
   logic [31:0]  pkt_cnt_o;

   int   checks;
   int   errors;
   int   src_idx [2];
   int   src_len [2];
   logic src_on  [2];
   logic src_rep [2];

   ireq_arbiter #(.NUM_REQ(2), .MAX_BEATS(33), .CNT_W(16)) dut (
      .log_clk          (clk),
      .log_rst_n        (rst_n),
      .link_initialized (link),
      .req_tvalid_in    (req_tvalid),
      .req_tready_o     (req_tready_o),
      .req_tlast_in     (req_tlast),
      .req_tdata_in     (req_tdata),
      .req_tkeep_in     (req_tkeep),
      .req_tuser_in     (req_tuser),
      .ireq_tvalid_o    (ireq_tvalid_o),
      .ireq_tready_in   (ireq_tready),
      .ireq_tlast_o     (ireq_tlast_o),
      .ireq_tdata_o     (ireq_tdata_o),
      .ireq_tkeep_o     (ireq_tkeep_o),
      .ireq_tuser_o     (ireq_tuser_o),
      .grant_o          (grant_o),
      .busy_o           (busy_o),
      .overrun_o        (overrun_o),
      .pkt_cnt_o        (pkt_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] beat_data(input int r, input int b);
      return {8'(8'hA0 + 8'(r)), 24'h000000, 32'(b)};
   endfunction

   function automatic logic [31:0] user_of(input int r);
      return {16'(16'h1000 + 16'(r)), 16'(16'h2000 + 16'(r))};
   endfunction

   task automatic drive_srcs();
      for (int r = 0; r < 2; r++) begin
         req_tvalid[r]          = src_on[r];
         req_tlast[r]           = src_on[r] && (src_idx[r] == src_len[r] - 1);
         req_tdata[r*64 +: 64]  = beat_data(r, src_idx[r]);
         req_tkeep[r*8 +: 8]    = 8'(8'hFF >> r);
         req_tuser[r*32 +: 32]  = user_of(r);
      end
   endtask

   // Advance one clock, moving each source on when its beat was accepted
   task automatic tick();
      logic [1:0] hs;
      #1;
      hs = req_tvalid & req_tready_o;
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
         if (hs[r]) begin
            src_idx[r]++;
            if (src_idx[r] == src_len[r]) begin
               src_idx[r] = 0;
               if (!src_rep[r]) src_on[r] = 1'b0;
            end
         end
      end
      drive_srcs();
      #1;
   endtask

   task automatic apply_reset();
      for (int r = 0; r < 2; r++) begin
         src_idx[r] = 0; src_len[r] = 1; src_on[r] = 1'b0; src_rep[r] = 1'b0;
      end
      drive_srcs();
      link        = 1'b1;
      ireq_tready = 1'b1;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (grant_o !== 2'b00 || busy_o !== 1'b0 || overrun_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: grant=%b busy=%b overrun=%b, required 00/0/0", grant_o, busy_o, overrun_o);
      end
      checks++;
      if (pkt_cnt_o !== 32'h0 || ireq_tvalid_o !== 1'b0 || req_tready_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_data: pkt_cnt=%h tvalid=%b tready=%b, required 0/0/00", pkt_cnt_o, ireq_tvalid_o, req_tready_o);
      end
   endtask

   task automatic test_single();
      apply_reset();
      src_len[0] = 5; src_on[0] = 1'b1;
      drive_srcs();
      #1;
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL single_pregrant: got %b required 00", grant_o);
      end
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL single_grant: got %b required 01", grant_o);
      end
      for (int b = 0; b < 5; b++) begin
         checks++;
         if (ireq_tvalid_o !== 1'b1 || ireq_tdata_o !== beat_data(0, b) || ireq_tlast_o !== (b == 4)) begin
            errors++;
            $display("FAIL single_beat%0d: valid=%b data=%h last=%b, required 1/%h/%b", b, ireq_tvalid_o, ireq_tdata_o, ireq_tlast_o, beat_data(0, b), (b == 4));
         end
         checks++;
         if (ireq_tuser_o !== 32'h1000_2000 || ireq_tkeep_o !== 8'hFF) begin
            errors++;
            $display("FAIL single_side%0d: user=%h keep=%h, required 10002000/ff", b, ireq_tuser_o, ireq_tkeep_o);
         end
         tick();
      end
      checks++;
      if (grant_o !== 2'b00 || busy_o !== 1'b0 || pkt_cnt_o !== 32'h0000_0001) begin
         errors++;
         $display("FAIL single_done: grant=%b busy=%b pkt_cnt=%h, required 00/0/00000001", grant_o, busy_o, pkt_cnt_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g;
      int         ph;
      int         owner;
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         src_len[r] = 2; src_on[r] = 1'b1; src_rep[r] = 1'b1;
      end
      drive_srcs();
      for (int k = 0; k < 12; k++) begin
         tick();
         ph    = k % 3;
         owner = (k / 3) % 2;
         exp_g = (ph == 2) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
         checks++;
         if (grant_o !== exp_g) begin
            errors++; $display("FAIL b2b_grant_c%0d: got %b required %b", k, grant_o, exp_g);
         end
         checks++;
         if (ph == 2) begin
            if (ireq_tvalid_o !== 1'b0) begin
               errors++; $display("FAIL b2b_bubble_c%0d: tvalid got %b required 0", k, ireq_tvalid_o);
            end
         end else if (ireq_tvalid_o !== 1'b1 || ireq_tdata_o !== beat_data(owner, ph) || ireq_tlast_o !== (ph == 1)) begin
            errors++;
            $display("FAIL b2b_beat_c%0d: valid=%b data=%h last=%b, required 1/%h/%b", k, ireq_tvalid_o, ireq_tdata_o, ireq_tlast_o, beat_data(owner, ph), (ph == 1));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rdy_pat;
      int          rx;
      bit          done;
      rdy_pat = 32'hB5E3_9C4D;
      rx      = 0;
      done    = 1'b0;
      apply_reset();
      src_len[1] = 33; src_on[1] = 1'b1;
      drive_srcs();
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         ireq_tready = rdy_pat[5'(cyc % 32)];
         #1;
         if (grant_o === 2'b10) begin
            checks++;
            if (ireq_tvalid_o !== 1'b1) begin
               errors++; $display("FAIL bp_valid_c%0d: got %b required 1", cyc, ireq_tvalid_o);
            end
         end
         if (ireq_tvalid_o && ireq_tready) begin
            checks++;
            if (ireq_tdata_o !== beat_data(1, rx) || ireq_tlast_o !== (rx == 32)) begin
               errors++;
               $display("FAIL bp_beat%0d: data=%h last=%b, required %h/%b", rx, ireq_tdata_o, ireq_tlast_o, beat_data(1, rx), (rx == 32));
            end
            rx++;
         end
         tick();
         done = !src_on[1];
      end
      ireq_tready = 1'b1;
      checks++;
      if (!done || rx != 33 || pkt_cnt_o !== 32'h0001_0000) begin
         errors++;
         $display("FAIL bp_total: done=%0d beats=%0d pkt_cnt=%h, required 1/33/00010000", done, rx, pkt_cnt_o);
      end
   endtask

   task automatic test_overrun();
      int  n0;
      int  n1;
      int  ovr;
      bit  done;
      n0 = 0; n1 = 0; ovr = 0; done = 1'b0;
      apply_reset();
      src_len[0] = 40; src_on[0] = 1'b1;
      src_len[1] = 1;  src_on[1] = 1'b1;
      drive_srcs();
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         #1;
         if (overrun_o) begin
            ovr++;
            checks++;
            if (n0 != 33) begin
               errors++; $display("FAIL ovr_pulse_pos: beats before pulse %0d required 33", n0);
            end
         end
         if (n0 == 33 && grant_o === 2'b01) begin
            checks++;
            if (ireq_tvalid_o !== 1'b0 || req_tready_o !== 2'b01) begin
               errors++;
               $display("FAIL ovr_drain_c%0d: tvalid=%b tready=%b, required 0/01", cyc, ireq_tvalid_o, req_tready_o);
            end
         end
         if (ireq_tvalid_o && ireq_tready && grant_o === 2'b01) begin
            checks++;
            if (ireq_tdata_o !== beat_data(0, n0) || ireq_tlast_o !== (n0 == 32)) begin
               errors++;
               $display("FAIL ovr_beat%0d: data=%h last=%b, required %h/%b", n0, ireq_tdata_o, ireq_tlast_o, beat_data(0, n0), (n0 == 32));
            end
            n0++;
         end else if (ireq_tvalid_o && ireq_tready && grant_o === 2'b10) begin
            checks++;
            if (ireq_tdata_o !== beat_data(1, 0) || ireq_tlast_o !== 1'b1 || src_on[0] !== 1'b0) begin
               errors++;
               $display("FAIL ovr_req1: data=%h last=%b req0_busy=%b, required %h/1/0", ireq_tdata_o, ireq_tlast_o, src_on[0], beat_data(1, 0));
            end
            n1++;
         end
         tick();
         done = (n1 == 1);
      end
      checks++;
      if (!done || n0 != 33 || ovr != 1) begin
         errors++; $display("FAIL ovr_counts: done=%0d beats=%0d pulses=%0d, required 1/33/1", done, n0, ovr);
      end
      checks++;
      if (pkt_cnt_o !== 32'h0001_0000) begin
         errors++; $display("FAIL ovr_pkt_cnt: got %h required 00010000", pkt_cnt_o);
      end
   endtask

   task automatic test_link();
      apply_reset();
      link = 1'b0;
      src_len[1] = 3; src_on[1] = 1'b1;
      drive_srcs();
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (grant_o !== 2'b00 || ireq_tvalid_o !== 1'b0) begin
            errors++; $display("FAIL link_down_c%0d: grant=%b tvalid=%b, required 00/0", c, grant_o, ireq_tvalid_o);
         end
      end
      link = 1'b1;
      tick();
      checks++;
      if (grant_o !== 2'b10 || ireq_tdata_o !== beat_data(1, 0)) begin
         errors++; $display("FAIL link_up_grant: grant=%b data=%h, required 10/%h", grant_o, ireq_tdata_o, beat_data(1, 0));
      end
      tick();
      link = 1'b0;
      src_len[0] = 1; src_on[0] = 1'b1;
      drive_srcs();
      for (int c = 0; c < 10 && src_on[1]; c++) tick();
      checks++;
      if (src_on[1] !== 1'b0 || pkt_cnt_o !== 32'h0001_0000) begin
         errors++; $display("FAIL link_drop_complete: pending=%b pkt_cnt=%h, required 0/00010000", src_on[1], pkt_cnt_o);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (grant_o !== 2'b00 || req_tready_o !== 2'b00) begin
            errors++; $display("FAIL link_blocked_c%0d: grant=%b tready=%b, required 00/00", c, grant_o, req_tready_o);
         end
      end
      link = 1'b1;
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL link_regrant: got %b required 01", grant_o);
      end
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      src_len[0] = 1; src_on[0] = 1'b1;
      drive_srcs();
      tick();
      tick();
      checks++;
      if (pkt_cnt_o !== 32'h0000_0001 || grant_o !== 2'b00) begin
         errors++; $display("FAIL rst_pre_pkt: pkt_cnt=%h grant=%b, required 00000001/00", pkt_cnt_o, grant_o);
      end
      src_len[1] = 6; src_on[1] = 1'b1;
      drive_srcs();
      tick();
      tick();
      tick();
      checks++;
      if (grant_o !== 2'b10 || ireq_tvalid_o !== 1'b1 || ireq_tdata_o !== beat_data(1, 2)) begin
         errors++;
         $display("FAIL rst_beat3: grant=%b valid=%b data=%h, required 10/1/%h", grant_o, ireq_tvalid_o, ireq_tdata_o, beat_data(1, 2));
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant_o !== 2'b00 || busy_o !== 1'b0 || ireq_tvalid_o !== 1'b0 || ireq_tlast_o !== 1'b0 ||
          ireq_tdata_o !== 64'h0 || req_tready_o !== 2'b00 || pkt_cnt_o !== 32'h0 || overrun_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: grant=%b busy=%b valid=%b last=%b data=%h tready=%b pkt_cnt=%h, required all 0",
                  grant_o, busy_o, ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o, req_tready_o, pkt_cnt_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int r = 0; r < 2; r++) begin
         src_idx[r] = 0; src_len[r] = 1; src_on[r] = 1'b1;
      end
      drive_srcs();
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL rst_priority: got %b required 01", grant_o);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      link        = 1'b0;
      ireq_tready = 1'b0;
      req_tvalid  = '0;
      req_tlast   = '0;
      req_tdata   = '0;
      req_tkeep   = '0;
      req_tuser   = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_overrun();
      test_link();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ireq_arbiter.md
# ireq_arbiter

Packet-granular round-robin arbiter sharing the single SRIO initiator request (ireq) AXI-Stream channel among NUM_REQ local requesters (doorbell generator, NWR streamer, future maintenance source). It sits between the requester blocks and the SRIO logical-layer ireq port in the log_clk domain. It never interleaves beats of different packets, and it truncates and drains any requester that exceeds the 256-byte payload limit.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- MAX_BEATS, 33: max beats per packet (1 header + 32 × 8-byte data).
- CNT_W, 16: width of the per-requester packet counters.

Ports:
- log_clk  in  1  logical-layer clock.
- log_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- link_initialized  in  1  new grants only while high.
- req_tvalid_in  in  NUM_REQ  per-requester valid.
- req_tready_o  out  NUM_REQ  per-requester ready.
- req_tlast_in  in  NUM_REQ  per-requester last.
- req_tdata_in  in  64×NUM_REQ  requester i in bits [64i+63:64i].
- req_tkeep_in  in  8×NUM_REQ  per-requester keep.
- req_tuser_in  in  32×NUM_REQ  {src_id, des_id} per requester.
- ireq_tvalid_o / ireq_tready_in / ireq_tlast_o  out/in/out  1  ireq handshake.
- ireq_tdata_o  out  64;  ireq_tkeep_o  out  8;  ireq_tuser_o  out  32  ireq payload.
- grant_o  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy_o  out  1  high in XFER or DRAIN.
- overrun_o  out  1  one-cycle pulse when a packet is truncated.
- pkt_cnt_o  out  CNT_W×NUM_REQ  completed-packet count per requester; wraps.

## Operation
- FSM states IDLE, XFER, DRAIN. Reset enters IDLE.
- IDLE: if link_initialized and any req_tvalid_in, pick the first valid requester searching from last_grant+1 modulo NUM_REQ. Register grant_o, go to XFER. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- XFER: ireq_* = granted requester's signals (combinational mux). Granted req_tready_o = ireq_tready_in; all others 0. beat_cnt increments on each ireq handshake.
  - Handshake with tlast: increment pkt_cnt of the granted requester, set last_grant to it, clear grant_o, go to IDLE.
  - Handshake with beat_cnt == MAX_BEATS-1 and no tlast: force ireq_tlast_o=1 on that beat, pulse overrun_o, go to DRAIN. pkt_cnt is not incremented.
- DRAIN: ireq_tvalid_o=0. Granted req_tready_o=1, discarding beats. On a requester tlast handshake, go to IDLE and update last_grant.
- A link_initialized drop mid-packet does not abort XFER or DRAIN; it only blocks the next grant.
- Non-granted requesters see tready=0 at all times. Their tvalid may rise and fall freely.

## Timing
- Reset values: all outputs 0, grant_o=0, pkt_cnt_o=0, beat_cnt=0.
- Arbitration latency: tvalid seen in IDLE at cycle t → grant_o and first beat visible at t+1.
- Back-to-back packets: tlast handshake at t → IDLE at t+1 → next first beat at t+2. This gives one bubble cycle minimum.
- Data path is zero-latency while granted; ireq_tvalid_o follows req_tvalid_in of the owner in the same cycle. Beats are never dropped or duplicated under ireq_tready_in backpressure.
- beat_cnt is 6 bits, cleared on entering XFER. Width must hold MAX_BEATS.
- Asynchronous reset mid-packet returns to IDLE immediately. The downstream sees a truncated packet; recovery is the link layer's concern.
- A single-beat packet (tlast on beat 0) is legal and counted.

## Structure
- Package srio_ireq_pkg: FTYPE constants (DOORB=4'hA, NWR=4'h5, TNWR=4'h4), MAX_BEATS default, state encoding (IDLE=2'd0, XFER=2'd1, DRAIN=2'd2).
- Sub-module rr_arb_pick: purely combinational. Takes NUM_REQ valid vector and last_grant index; returns one-hot pick and index. Reusable by future iresp/tresp arbiters.

## Test plan
- Reset, link_initialized=1, only req0 sends a 5-beat NWR packet → grant_o=01 one cycle after tvalid, 5 beats out in order, pkt_cnt[0]=1, grant_o=0 afterwards.
- req0 and req1 both continuously valid with 2-beat packets → grants alternate 0,1,0,1. Each packet is contiguous, with exactly one idle cycle between packets.
- ireq_tready_in toggled randomly during a 33-beat req1 packet → all 33 beats match the source, tlast only on beat 33, no duplicates.
- req0 sends 40 beats without tlast → beat 33 carries forced ireq_tlast_o=1, overrun_o pulses once, beats 34–40 are consumed with ireq_tvalid_o=0, pkt_cnt[0] unchanged, then req1 is granted.
- link_initialized=0 with req1 valid → no grant. Deassert link_initialized mid-packet → the packet completes and no new grant follows.
- Assert log_rst_n=0 during beat 3 of a packet → all outputs 0 the same cycle. After release, requester 0 has priority again.
